// File: rtl/vedic_divider8by4.sv
// Sequential restoring divider, 8-bit dividend by 4-bit divisor, one quotient bit per clock.
// A zero divisor completes immediately with all-ones quotient/remainder and the dbz flag set.
module vedic_divider8by4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] N,
  input  logic [3:0] D,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] pr_q, pr_d;
  logic [7:0] qs_q, qs_d;
  logic [3:0] d_r_q, d_r_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       dbz_q, dbz_d;

  logic [4:0] shifted;
  logic [4:0] t;
  logic       borrow;

  always_comb begin
    shifted       = {pr_q[3:0], qs_q[7]};
    {borrow, t}   = {1'b0, shifted} - {2'b00, d_r_q};

    state_d = state_q;
    pr_d    = pr_q;
    qs_d    = qs_q;
    d_r_d   = d_r_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      RUN: begin
        // Restore on borrow by keeping the shifted value instead of the difference.
        pr_d  = borrow ? shifted : t;
        qs_d  = {qs_q[6:0], ~borrow};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          q_d     = {qs_q[6:0], ~borrow};
          r_d     = pr_d[3:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          if (D != 4'd0) begin
            pr_d    = 5'd0;
            qs_d    = N;
            d_r_d   = D;
            cnt_d   = 3'd0;
            state_d = RUN;
          end else begin
            q_d     = 8'hFF;
            r_d     = 4'hF;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    pr_q  <= pr_d;
    qs_q  <= qs_d;
    d_r_q <= d_r_d;
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      q_q     <= 8'd0;
      r_q     <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign dbz  = dbz_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_vedic_divider8by4.sv
// Self-checking bench for vedic_divider8by4: directed cases, randomized operands and an
// exhaustive product/divisor sweep, all checked against plain integer division.
module tb_vedic_divider8by4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] N;
  logic [3:0] D;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       dbz;

  int total = 0;
  int bad   = 0;

  logic [7:0] prev_q;
  logic [3:0] prev_r;
  logic       prev_dbz;

  vedic_divider8by4 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .N    (N),
    .D    (D),
    .Q    (Q),
    .R    (R),
    .busy (busy),
    .done (done),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one division; optionally disturb N/D/start while the divider is busy.
  task automatic run_div(input logic [7:0] n, input logic [3:0] d, input bit scramble,
                         input string tag);
    logic [7:0] eq;
    logic [3:0] er;
    logic       ed;
    int         exp_cyc;
    int         cyc;
    if (d == 4'd0) begin
      eq = 8'hFF; er = 4'hF; ed = 1'b1; exp_cyc = 1;
    end else begin
      eq = n / d; er = n % d; ed = 1'b0; exp_cyc = 9;
    end
    @(negedge clk);
    N = n; D = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    if (d != 4'd0) chk({tag, "_busy_after_accept"}, busy, 1);
    while (!done && cyc < 20) begin
      chk({tag, "_hold_q"}, Q, prev_q);
      chk({tag, "_hold_r"}, R, prev_r);
      if (scramble && cyc < 7) begin
        N = 8'($urandom);
        D = 4'($urandom);
        start = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_q"}, Q, eq);
    chk({tag, "_r"}, R, er);
    chk({tag, "_dbz"}, dbz, ed);
    prev_q = eq; prev_r = er; prev_dbz = ed;
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int c;
    int c1;
    logic [7:0] rn;
    logic [3:0] rd;
    rst = 1'b1; start = 1'b0; N = 8'd0; D = 4'd0;
    prev_q = 8'd0; prev_r = 4'd0; prev_dbz = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_q", Q, 0);
    chk("reset_r", R, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", dbz, 0);
    rst = 1'b0;

    run_div(8'd221, 4'd13, 0, "d221_13");
    run_div(8'd200, 4'd7,  0, "d200_7");
    run_div(8'd255, 4'd1,  0, "d255_1");
    run_div(8'd3,   4'd15, 0, "d3_15");
    run_div(8'd42,  4'd0,  0, "dbz42");
    run_div(8'd150, 4'd11, 1, "scramble");

    // Back-to-back with start held high; second operands presented while busy.
    @(negedge clk);
    N = 8'd225; D = 4'd15; start = 1'b1;
    @(negedge clk);
    N = 8'd100; D = 4'd9;
    c = 1;
    while (!done && c < 20) begin @(negedge clk); c++; end
    chk("b2b_lat1", c, 9);
    chk("b2b_q1", Q, 225 / 15);
    chk("b2b_r1", R, 225 % 15);
    c1 = c;
    @(negedge clk);
    start = 1'b0;
    c++;
    chk("b2b_restart_busy", busy, 1);
    chk("b2b_restart_done", done, 0);
    while (!done && c < 40) begin @(negedge clk); c++; end
    chk("b2b_gap", c - c1, 9);
    chk("b2b_q2", Q, 100 / 9);
    chk("b2b_r2", R, 100 % 9);
    prev_q = 8'(100 / 9); prev_r = 4'(100 % 9); prev_dbz = 1'b0;
    @(negedge clk);
    chk("b2b_done_pulse", done, 0);

    // Reset in the middle of an iteration, with start also asserted.
    @(negedge clk);
    N = 8'd200; D = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_mid_q", Q, 0);
    chk("rst_mid_r", R, 0);
    chk("rst_mid_dbz", dbz, 0);
    chk("rst_mid_busy_after", busy, 0);
    chk("rst_mid_done", done, 0);
    c = 0;
    repeat (12) begin @(negedge clk); if (done || busy) c++; end
    chk("rst_mid_quiet", c, 0);
    prev_q = 8'd0; prev_r = 4'd0; prev_dbz = 1'b0;

    for (int i = 0; i < 30; i++) begin
      rn = 8'($urandom);
      rd = (i % 7 == 0) ? 4'd0 : 4'($urandom);
      run_div(rn, rd, (i % 2) == 1, "rand");
    end

    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        run_div(8'(a * b), 4'(b), 0, "sweep");
        chk("sweep_q_is_a", Q, a);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
